// File: rtl/iic_rdtx_module.sv
// rtl/iic_rdtx_module.sv - EEPROM read-data transmitter: prefetch, MSB-first SDA shift, master ACK/NACK sampling
module iic_rdtx_module #(
  parameter logic [7:0] FILL_BYTE = 8'hFF,
  parameter logic       ACK_LVL   = 1'b0
) (
  input  logic       iic_clk_c,
  input  logic       iic_sys_rst_n,
  input  logic       iic_frm_rst_n,
  input  logic       rd_start,
  input  logic       sda_in,
  output logic       mem_rd_req,
  input  logic       mem_rd_ack,
  input  logic [7:0] mem_rd_data,
  output logic       iic_sda_out,
  output logic       iic_sda_oe,
  output logic       iic_addr_inc,
  output logic       iic_addr_dec,
  output logic       iic_rd_nack,
  output logic       iic_rd_underrun,
  output logic       iic_rd_busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_ACK, ST_DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic        sda_out_q, sda_out_d;
  logic        sda_oe_q, sda_oe_d;
  logic        inc_q, inc_d;
  logic        dec_q, dec_d;
  logic        nack_q, nack_d;
  logic        underrun_q, underrun_d;

  logic        busy, hold_eff, accept, ack_ok, nack_ev, load;
  logic [7:0]  load_byte;
  logic        frm_all_rst_n;

  assign frm_all_rst_n = iic_sys_rst_n & iic_frm_rst_n;

  assign busy     = (state_q == ST_SHIFT) || (state_q == ST_ACK);
  // A repeated start discards the prefetched byte so the restart fetches fresh data.
  assign hold_eff = hold_vld_q & ~rd_start;
  assign mem_rd_req = (rd_start | busy) & ~hold_eff;
  assign accept   = mem_rd_req & mem_rd_ack;
  assign ack_ok   = (state_q == ST_ACK) && (sda_in == ACK_LVL);
  assign nack_ev  = (state_q == ST_ACK) && (sda_in != ACK_LVL) && !rd_start;
  assign load     = rd_start | ack_ok;
  assign load_byte = accept ? mem_rd_data : (hold_eff ? hold_q : FILL_BYTE);

  always_ff @(posedge iic_clk_c or negedge frm_all_rst_n) begin
    if (!frm_all_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    if (load) begin
      state_d   = ST_SHIFT;
      bit_cnt_d = 3'd7;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          bit_cnt_d = bit_cnt_q - 3'd1;
          if (bit_cnt_q == 3'd0) state_d = ST_ACK;
        end
        ST_ACK:  state_d = ST_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    shift_d    = shift_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    sda_oe_d   = 1'b0;
    sda_out_d  = 1'b1;
    inc_d      = accept;
    dec_d      = 1'b0;
    nack_d     = 1'b0;
    underrun_d = rd_start ? 1'b0 : underrun_q;
    if (load) begin
      shift_d    = load_byte;
      sda_out_d  = load_byte[7];
      sda_oe_d   = 1'b1;
      hold_vld_d = 1'b0;
      if (!accept && !hold_eff) underrun_d = 1'b1;
    end else begin
      if (accept) begin
        hold_d     = mem_rd_data;
        hold_vld_d = 1'b1;
      end
      if (state_q == ST_SHIFT) begin
        shift_d = {shift_q[6:0], 1'b0};
        if (bit_cnt_q != 3'd0) begin
          sda_oe_d  = 1'b1;
          sda_out_d = shift_q[6];
        end
      end
      // A byte accepted on the NACK edge is abandoned too, so it also earns a decrement.
      if (nack_ev) begin
        nack_d     = 1'b1;
        dec_d      = hold_vld_q | accept;
        hold_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge iic_clk_c or negedge frm_all_rst_n) begin
    if (!frm_all_rst_n) begin
      bit_cnt_q  <= 3'd7;
      hold_vld_q <= 1'b0;
      sda_out_q  <= 1'b1;
      sda_oe_q   <= 1'b0;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      hold_vld_q <= hold_vld_d;
      sda_out_q  <= sda_out_d;
      sda_oe_q   <= sda_oe_d;
      inc_q      <= inc_d;
      dec_q      <= dec_d;
      nack_q     <= nack_d;
    end
  end

  // Underrun and the data registers survive a frame reset.
  always_ff @(posedge iic_clk_c or negedge iic_sys_rst_n) begin
    if (!iic_sys_rst_n) begin
      underrun_q <= 1'b0;
      shift_q    <= 8'h00;
      hold_q     <= 8'h00;
    end else begin
      underrun_q <= underrun_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
    end
  end

  assign iic_sda_out     = sda_out_q;
  assign iic_sda_oe      = sda_oe_q;
  assign iic_addr_inc    = inc_q;
  assign iic_addr_dec    = dec_q;
  assign iic_rd_nack     = nack_q;
  assign iic_rd_underrun = underrun_q;
  assign iic_rd_busy     = busy;

endmodule

// File: tb/tb_iic_rdtx_module.sv
// tb/tb_iic_rdtx_module.sv - directed self-checking bench for iic_rdtx_module
module tb_iic_rdtx_module;

  logic       iic_clk_c = 1'b0;
  logic       iic_sys_rst_n = 1'b0;
  logic       iic_frm_rst_n = 1'b1;
  logic       rd_start = 1'b0;
  logic       sda_in = 1'b0;
  logic       mem_rd_req;
  logic       mem_rd_ack;
  logic [7:0] mem_rd_data;
  logic       iic_sda_out, iic_sda_oe, iic_addr_inc, iic_addr_dec;
  logic       iic_rd_nack, iic_rd_underrun, iic_rd_busy;

  logic       ack_en = 1'b1;
  logic [7:0] mem_bytes [0:63];
  logic [5:0] fetch_idx = 6'd0;
  int         inc_cnt = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 iic_clk_c = ~iic_clk_c;

  assign mem_rd_ack  = ack_en & mem_rd_req;
  assign mem_rd_data = mem_bytes[fetch_idx];

  always @(posedge iic_clk_c) begin
    if (mem_rd_req === 1'b1 && mem_rd_ack === 1'b1) fetch_idx <= fetch_idx + 6'd1;
    if (iic_addr_inc === 1'b1) inc_cnt <= inc_cnt + 1;
  end

  iic_rdtx_module dut (
    .iic_clk_c(iic_clk_c), .iic_sys_rst_n(iic_sys_rst_n), .iic_frm_rst_n(iic_frm_rst_n),
    .rd_start(rd_start), .sda_in(sda_in),
    .mem_rd_req(mem_rd_req), .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data),
    .iic_sda_out(iic_sda_out), .iic_sda_oe(iic_sda_oe),
    .iic_addr_inc(iic_addr_inc), .iic_addr_dec(iic_addr_dec),
    .iic_rd_nack(iic_rd_nack), .iic_rd_underrun(iic_rd_underrun), .iic_rd_busy(iic_rd_busy)
  );

  task automatic tick;
    @(posedge iic_clk_c);
    @(negedge iic_clk_c);
  endtask

  task automatic frame_pulse;
    iic_frm_rst_n = 1'b0;
    tick();
    iic_frm_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    logic [7:0] obs;
    tick();
    obs = {iic_sda_out, iic_sda_oe, iic_addr_inc, iic_addr_dec, iic_rd_nack, iic_rd_underrun, iic_rd_busy, mem_rd_req};
    n_cmp++;
    if (obs !== 8'b1000_0000) begin
      n_err++;
      $display("FAIL reset_outputs got %b exp %b", obs, 8'b1000_0000);
    end
    iic_sys_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    logic [7:0] b0, b1;
    int inc0;
    b0 = 8'hA5; b1 = 8'h3C;
    mem_bytes[fetch_idx]        = b0;
    mem_bytes[fetch_idx + 6'd1] = b1;
    mem_bytes[fetch_idx + 6'd2] = 8'h5A;
    inc0 = inc_cnt;
    ack_en = 1'b1; sda_in = 1'b0;
    rd_start = 1'b1; #1;
    n_cmp++;
    if (mem_rd_req !== 1'b1) begin n_err++; $display("FAIL basic_req_on_start got %b exp 1", mem_rd_req); end
    tick(); rd_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (iic_sda_oe !== 1'b1 || iic_sda_out !== b0[7-i]) begin
        n_err++; $display("FAIL basic_byte0_bit%0d got oe=%b out=%b exp oe=1 out=%b", 7-i, iic_sda_oe, iic_sda_out, b0[7-i]);
      end
      tick();
    end
    n_cmp++;
    if (iic_sda_oe !== 1'b0 || iic_rd_busy !== 1'b1) begin
      n_err++; $display("FAIL basic_ack_slot got oe=%b busy=%b exp oe=0 busy=1", iic_sda_oe, iic_rd_busy);
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (iic_sda_oe !== 1'b1 || iic_sda_out !== b1[7-i]) begin
        n_err++; $display("FAIL basic_byte1_bit%0d got oe=%b out=%b exp oe=1 out=%b", 7-i, iic_sda_oe, iic_sda_out, b1[7-i]);
      end
      tick();
    end
    n_cmp++;
    if (inc_cnt - inc0 !== 3) begin n_err++; $display("FAIL basic_inc_count got %0d exp 3", inc_cnt - inc0); end
    sda_in = 1'b1;
    tick();
    sda_in = 1'b0;
    n_cmp++;
    if (iic_rd_nack !== 1'b1 || iic_rd_busy !== 1'b0) begin
      n_err++; $display("FAIL basic_end_nack got nack=%b busy=%b exp nack=1 busy=0", iic_rd_nack, iic_rd_busy);
    end
    tick();
  endtask

  task automatic test_nack;
    mem_bytes[fetch_idx]        = 8'h11;
    mem_bytes[fetch_idx + 6'd1] = 8'h22;
    ack_en = 1'b1; sda_in = 1'b0;
    rd_start = 1'b1;
    tick(); rd_start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    sda_in = 1'b1;
    tick();
    sda_in = 1'b0;
    n_cmp++;
    if ({iic_rd_nack, iic_addr_dec, iic_sda_oe, mem_rd_req, iic_rd_busy} !== 5'b11000) begin
      n_err++; $display("FAIL nack_pulse got nack,dec,oe,req,busy=%b exp 11000",
                        {iic_rd_nack, iic_addr_dec, iic_sda_oe, mem_rd_req, iic_rd_busy});
    end
    tick();
    n_cmp++;
    if ({iic_rd_nack, iic_addr_dec, iic_sda_oe, mem_rd_req, iic_rd_busy} !== 5'b00000) begin
      n_err++; $display("FAIL nack_done got nack,dec,oe,req,busy=%b exp 00000",
                        {iic_rd_nack, iic_addr_dec, iic_sda_oe, mem_rd_req, iic_rd_busy});
    end
    tick();
  endtask

  task automatic test_underrun;
    logic [7:0] late, nxt;
    late = 8'h77; nxt = 8'h81;
    mem_bytes[fetch_idx]        = late;
    mem_bytes[fetch_idx + 6'd1] = nxt;
    ack_en = 1'b0; sda_in = 1'b0;
    rd_start = 1'b1;
    tick(); rd_start = 1'b0;
    n_cmp++;
    if (iic_rd_underrun !== 1'b1) begin n_err++; $display("FAIL underrun_set got %b exp 1", iic_rd_underrun); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (iic_sda_oe !== 1'b1 || iic_sda_out !== 1'b1) begin
        n_err++; $display("FAIL underrun_fill_bit%0d got oe=%b out=%b exp oe=1 out=1", 7-i, iic_sda_oe, iic_sda_out);
      end
      tick();
    end
    tick(); tick(); tick();
    ack_en = 1'b1; #1;
    n_cmp++;
    if (mem_rd_req !== 1'b1) begin n_err++; $display("FAIL underrun_late_req got %b exp 1", mem_rd_req); end
    tick(); ack_en = 1'b0;
    n_cmp++;
    if (iic_addr_inc !== 1'b1) begin n_err++; $display("FAIL underrun_late_inc got %b exp 1", iic_addr_inc); end
    for (int i = 0; i < 6; i++) tick();
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (iic_sda_oe !== 1'b1 || iic_sda_out !== late[7-i]) begin
        n_err++; $display("FAIL underrun_late_bit%0d got oe=%b out=%b exp oe=1 out=%b", 7-i, iic_sda_oe, iic_sda_out, late[7-i]);
      end
      tick();
    end
    sda_in = 1'b1;
    tick();
    sda_in = 1'b0;
    n_cmp++;
    if ({iic_rd_nack, iic_addr_dec, iic_rd_underrun} !== 3'b101) begin
      n_err++; $display("FAIL underrun_nack got nack,dec,underrun=%b exp 101", {iic_rd_nack, iic_addr_dec, iic_rd_underrun});
    end
    ack_en = 1'b1;
    rd_start = 1'b1;
    tick(); rd_start = 1'b0;
    n_cmp++;
    if (iic_rd_underrun !== 1'b0 || iic_sda_out !== nxt[7]) begin
      n_err++; $display("FAIL underrun_clear got underrun=%b out=%b exp underrun=0 out=%b", iic_rd_underrun, iic_sda_out, nxt[7]);
    end
    frame_pulse();
  endtask

  task automatic test_frame_reset;
    logic [7:0] b0, br;
    logic [5:0] base;
    int inc0;
    b0 = 8'hC3; br = 8'h96;
    base = fetch_idx;
    mem_bytes[base]        = b0;
    mem_bytes[base + 6'd1] = 8'h44;
    mem_bytes[base + 6'd2] = br;
    mem_bytes[base + 6'd3] = 8'h55;
    ack_en = 1'b1; sda_in = 1'b0;
    rd_start = 1'b1;
    tick(); rd_start = 1'b0;
    tick(); tick(); tick();
    n_cmp++;
    if (iic_sda_oe !== 1'b1 || iic_sda_out !== b0[4]) begin
      n_err++; $display("FAIL frame_bit4 got oe=%b out=%b exp oe=1 out=%b", iic_sda_oe, iic_sda_out, b0[4]);
    end
    iic_frm_rst_n = 1'b0; #1;
    n_cmp++;
    if ({iic_sda_oe, iic_sda_out, iic_rd_busy, mem_rd_req} !== 4'b0100) begin
      n_err++; $display("FAIL frame_async got oe,out,busy,req=%b exp 0100", {iic_sda_oe, iic_sda_out, iic_rd_busy, mem_rd_req});
    end
    inc0 = inc_cnt;
    tick();
    iic_frm_rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({iic_addr_inc, iic_addr_dec, iic_rd_nack} !== 3'b000 || inc_cnt !== inc0) begin
      n_err++; $display("FAIL frame_no_pulses got inc,dec,nack=%b incs=%0d exp 000 incs=%0d",
                        {iic_addr_inc, iic_addr_dec, iic_rd_nack}, inc_cnt, inc0);
    end
    rd_start = 1'b1;
    tick(); rd_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (iic_sda_oe !== 1'b1 || iic_sda_out !== br[7-i]) begin
        n_err++; $display("FAIL frame_restart_bit%0d got oe=%b out=%b exp oe=1 out=%b", 7-i, iic_sda_oe, iic_sda_out, br[7-i]);
      end
      tick();
    end
    frame_pulse();
  endtask

  task automatic test_restart;
    logic [7:0] br;
    logic [5:0] base;
    br = 8'h66;
    base = fetch_idx;
    mem_bytes[base]        = 8'hF0;
    mem_bytes[base + 6'd1] = 8'h0F;
    mem_bytes[base + 6'd2] = br;
    mem_bytes[base + 6'd3] = 8'h99;
    ack_en = 1'b1; sda_in = 1'b0;
    rd_start = 1'b1;
    tick(); rd_start = 1'b0;
    tick(); tick();
    rd_start = 1'b1;
    tick(); rd_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (iic_sda_oe !== 1'b1 || iic_sda_out !== br[7-i] || iic_addr_dec !== 1'b0) begin
        n_err++; $display("FAIL restart_bit%0d got oe=%b out=%b dec=%b exp oe=1 out=%b dec=0",
                          7-i, iic_sda_oe, iic_sda_out, iic_addr_dec, br[7-i]);
      end
      tick();
    end
    frame_pulse();
  endtask

  task automatic test_sys_reset;
    ack_en = 1'b0; sda_in = 1'b0;
    rd_start = 1'b1;
    tick(); rd_start = 1'b0;
    tick(); tick();
    n_cmp++;
    if (iic_rd_underrun !== 1'b1 || iic_sda_oe !== 1'b1) begin
      n_err++; $display("FAIL sysrst_pre got underrun=%b oe=%b exp 1 1", iic_rd_underrun, iic_sda_oe);
    end
    iic_sys_rst_n = 1'b0; #1;
    n_cmp++;
    if ({iic_sda_out, iic_sda_oe, iic_addr_inc, iic_addr_dec, iic_rd_nack, iic_rd_underrun, iic_rd_busy, mem_rd_req} !== 8'b1000_0000) begin
      n_err++; $display("FAIL sysrst_async got %b exp %b",
                        {iic_sda_out, iic_sda_oe, iic_addr_inc, iic_addr_dec, iic_rd_nack, iic_rd_underrun, iic_rd_busy, mem_rd_req},
                        8'b1000_0000);
    end
    tick();
    iic_sys_rst_n = 1'b1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem_bytes[i] = 8'h00;
    @(negedge iic_clk_c);
    test_reset();
    test_basic();
    test_nack();
    test_underrun();
    test_frame_reset();
    test_restart();
    test_sys_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
